// File: rtl/multicycle_ctrl_hs.sv
// Multicycle control FSM for the 16-bit RISC datapath with memory ready
// handshakes, branch resolution in PC-update and a sticky timeout fault.
module multicycle_ctrl_hs #(
    parameter int WAIT_W     = 4,
    parameter int MAX_WAIT   = 15,
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       m,
    input  logic       take_branch,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_read,
    output logic       ir_en,
    output logic       pc_en,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_en,
    output logic       sign5,
    output logic       wr_byte,
    output logic       sign_w2b,
    output logic       opa_src,
    output logic       data_in_src,
    output logic [1:0] ra_sel,
    output logic [1:0] rb_sel,
    output logic [1:0] rw_sel,
    output logic [1:0] pc_src,
    output logic [1:0] busw_src,
    output logic [1:0] opb_src,
    output logic [4:0] func,
    output logic [2:0] r7,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_PCU   = 3'd1,
        S_IF    = 3'd2,
        S_ID    = 3'd3,
        S_EX    = 3'd4,
        S_MEM   = 3'd5,
        S_WB    = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    localparam logic [4:0] F_AND  = 5'b00000;
    localparam logic [4:0] F_ADD  = 5'b00010;
    localparam logic [4:0] F_SUB  = 5'b00100;
    localparam logic [4:0] F_ADDI = 5'b00110;
    localparam logic [4:0] F_ANDI = 5'b01000;
    localparam logic [4:0] F_LW   = 5'b01010;
    localparam logic [4:0] F_SW   = 5'b01110;
    localparam logic [4:0] F_JMP  = 5'b11000;
    localparam logic [4:0] F_CALL = 5'b11010;
    localparam logic [4:0] F_RET  = 5'b11100;
    localparam logic [4:0] F_SV   = 5'b11110;

    state_t            cur_state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [4:0]        func_q;
    logic [4:0]        func_d;
    logic              dec_b;
    logic              waiting;
    logic              timed_out;

    logic f_imm;
    logic f_alu;
    logic f_lw;
    logic f_lb;
    logic f_load;
    logic f_sw;
    logic f_sv;
    logic f_store;
    logic f_branch;
    logic f_jmp;
    logic f_call;
    logic f_ret;

    // Only the LB pair and the branch group use m to pick the variant.
    always_comb begin
        dec_b = 1'b0;
        if ((opcode == 4'b0110) || (opcode[3:2] == 2'b10)) begin
            dec_b = m;
        end
        func_d = {opcode, dec_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q <= '0;
        end else if (cur_state == S_ID) begin
            func_q <= func_d;
        end
    end

    assign f_imm    = (func_q == F_ADDI) || (func_q == F_ANDI);
    assign f_alu    = f_imm || (func_q == F_AND) ||
                      (func_q == F_ADD) || (func_q == F_SUB);
    assign f_lw     = (func_q == F_LW);
    assign f_lb     = (func_q[4:1] == 4'b0110);
    assign f_load   = f_lw || f_lb;
    assign f_sw     = (func_q == F_SW);
    assign f_sv     = (func_q == F_SV);
    assign f_store  = f_sw || f_sv;
    assign f_branch = (func_q[4:3] == 2'b10);
    assign f_jmp    = (func_q == F_JMP);
    assign f_call   = (func_q == F_CALL);
    assign f_ret    = (func_q == F_RET);

    assign waiting   = ((cur_state == S_IF) && !imem_ready) ||
                       ((cur_state == S_MEM) && !dmem_ready);
    assign timed_out = TIMEOUT_EN && waiting && (wait_cnt == MAX_CNT);

    // Counter is zero whenever the FSM is outside a waiting state,
    // so every entry into IF or MEM starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_START;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        unique case (cur_state)
            S_START: next_state = S_IF;
            S_IF: begin
                if (imem_ready) begin
                    next_state = S_ID;
                end else if (timed_out) begin
                    next_state = S_FAULT;
                end
            end
            S_ID: next_state = S_EX;
            S_EX: begin
                if (f_load || f_store) begin
                    next_state = S_MEM;
                end else if (f_alu || f_call) begin
                    next_state = S_WB;
                end else begin
                    next_state = S_PCU;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    next_state = f_load ? S_WB : S_PCU;
                end else if (timed_out) begin
                    next_state = S_FAULT;
                end
            end
            S_WB:    next_state = S_PCU;
            S_PCU:   next_state = S_IF;
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FAULT;
        endcase
    end

    always_comb begin
        imem_read = 1'b0;
        ir_en     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_en    = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 2'b00;
        fault     = 1'b0;
        unique case (cur_state)
            S_IF: begin
                imem_read = 1'b1;
                ir_en     = imem_ready;
            end
            S_MEM: begin
                mem_read  = f_load;
                mem_write = f_store;
            end
            S_WB: reg_en = 1'b1;
            S_PCU: begin
                pc_en = 1'b1;
                unique case (1'b1)
                    f_branch:       pc_src = {1'b0, take_branch};
                    f_jmp, f_call:  pc_src = 2'b10;
                    f_ret:          pc_src = 2'b11;
                    default:        pc_src = 2'b00;
                endcase
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        sign5       = 1'b0;
        wr_byte     = 1'b0;
        sign_w2b    = 1'b0;
        opa_src     = 1'b0;
        data_in_src = 1'b0;
        ra_sel      = 2'b00;
        rb_sel      = 2'b00;
        rw_sel      = 2'b00;
        busw_src    = 2'b00;
        opb_src     = 2'b00;
        unique case (1'b1)
            f_imm: begin
                sign5   = 1'b1;
                ra_sel  = 2'b01;
                rw_sel  = 2'b01;
                opb_src = 2'b01;
            end
            f_lw: begin
                sign5    = 1'b1;
                ra_sel   = 2'b01;
                rw_sel   = 2'b01;
                opb_src  = 2'b01;
                busw_src = 2'b01;
            end
            f_lb: begin
                sign5    = 1'b1;
                ra_sel   = 2'b01;
                rw_sel   = 2'b01;
                opb_src  = 2'b01;
                busw_src = 2'b10;
                sign_w2b = func_q[0];
            end
            f_sw: begin
                sign5   = 1'b1;
                ra_sel  = 2'b01;
                rb_sel  = 2'b01;
                opb_src = 2'b01;
            end
            f_branch: begin
                sign5  = 1'b1;
                ra_sel = 2'b01;
                rb_sel = 2'b01;
            end
            f_jmp: begin
                opa_src = 1'b1;
                opb_src = 2'b10;
            end
            f_call: begin
                opa_src  = 1'b1;
                opb_src  = 2'b10;
                rw_sel   = 2'b10;
                busw_src = 2'b11;
            end
            f_ret: rb_sel = 2'b10;
            f_sv: begin
                ra_sel      = 2'b10;
                data_in_src = 1'b1;
                wr_byte     = 1'b1;
            end
            default: ;
        endcase
    end

    assign func  = func_q;
    assign r7    = 3'b111;
    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Directed bench for multicycle_ctrl_hs: an instruction-level sequence model
// queues the expected per-cycle outputs and one process compares them.
module tb_multicycle_ctrl_hs;

    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] opcode;
    logic       m;
    logic       take_branch;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_read;
    logic       ir_en;
    logic       pc_en;
    logic       mem_read;
    logic       mem_write;
    logic       reg_en;
    logic       sign5;
    logic       wr_byte;
    logic       sign_w2b;
    logic       opa_src;
    logic       data_in_src;
    logic [1:0] ra_sel;
    logic [1:0] rb_sel;
    logic [1:0] rw_sel;
    logic [1:0] pc_src;
    logic [1:0] busw_src;
    logic [1:0] opb_src;
    logic [4:0] func;
    logic [2:0] r7;
    logic       fault;
    logic [2:0] state;

    multicycle_ctrl_hs dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .m(m),
        .take_branch(take_branch), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .imem_read(imem_read), .ir_en(ir_en),
        .pc_en(pc_en), .mem_read(mem_read), .mem_write(mem_write),
        .reg_en(reg_en), .sign5(sign5), .wr_byte(wr_byte),
        .sign_w2b(sign_w2b), .opa_src(opa_src), .data_in_src(data_in_src),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .rw_sel(rw_sel), .pc_src(pc_src),
        .busw_src(busw_src), .opb_src(opb_src), .func(func), .r7(r7),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        imem_read;
        logic        ir_en;
        logic        pc_en;
        logic        mem_read;
        logic        mem_write;
        logic        reg_en;
        logic        fault;
        logic [1:0]  pc_src;
        logic [4:0]  func;
        logic [14:0] sel;
        logic [2:0]  r7;
    } exp_t;

    typedef enum {K_ALU, K_LOAD, K_STORE, K_BR, K_JMP, K_CALL, K_RET} kind_t;

    exp_t       q[$];
    exp_t       ce;
    exp_t       ca;
    int         checks = 0;
    int         errors = 0;
    int         ncyc;
    int         n;
    logic [4:0] last_func;

    function automatic logic [4:0] model_func(input logic [3:0] op,
                                              input logic mb);
        logic b;
        b = ((op == 4'd6) || (op >= 4'd8 && op <= 4'd11)) ? mb : 1'b0;
        return {op, b};
    endfunction

    function automatic kind_t model_kind(input logic [4:0] f);
        kind_t k;
        k = K_ALU;
        if (f inside {5'd10, 5'd12, 5'd13}) k = K_LOAD;
        if (f inside {5'd14, 5'd30}) k = K_STORE;
        if (f >= 5'd16 && f <= 5'd23) k = K_BR;
        if (f == 5'd24) k = K_JMP;
        if (f == 5'd26) k = K_CALL;
        if (f == 5'd28) k = K_RET;
        return k;
    endfunction

    // Packed as {sign5,wr_byte,sign_w2b,opa_src,data_in_src,ra,rb,rw,busw,opb}.
    function automatic logic [14:0] sel_of(input logic [4:0] f);
        logic       s5, wb, sw2b, oa, di;
        logic [1:0] ra, rb, rw, bw, ob;
        {s5, wb, sw2b, oa, di} = 5'b0;
        {ra, rb, rw, bw, ob}   = 10'b0;
        if (f inside {5'd6, 5'd8, 5'd10, 5'd12, 5'd13}) begin
            s5 = 1'b1; ra = 2'd1; rw = 2'd1; ob = 2'd1;
        end
        if (f == 5'd10) bw = 2'd1;
        if (f inside {5'd12, 5'd13}) begin
            bw = 2'd2; sw2b = f[0];
        end
        if (f == 5'd14) begin
            s5 = 1'b1; ra = 2'd1; rb = 2'd1; ob = 2'd1;
        end
        if (f >= 5'd16 && f <= 5'd23) begin
            s5 = 1'b1; ra = 2'd1; rb = 2'd1;
        end
        if (f inside {5'd24, 5'd26}) begin
            oa = 1'b1; ob = 2'd2;
        end
        if (f == 5'd26) begin
            rw = 2'd2; bw = 2'd3;
        end
        if (f == 5'd28) rb = 2'd2;
        if (f == 5'd30) begin
            ra = 2'd2; di = 1'b1; wb = 1'b1;
        end
        return {s5, wb, sw2b, oa, di, ra, rb, rw, bw, ob};
    endfunction

    function automatic exp_t blank(input logic [2:0] st, input logic [4:0] f);
        exp_t e;
        e      = '0;
        e.st   = st;
        e.func = f;
        e.sel  = sel_of(f);
        e.r7   = 3'b111;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic step(input logic [3:0] op, input logic mb, input logic tbv,
                        input logic ir, input logic dr, input exp_t e);
        @(posedge clk);
        #1;
        opcode      = op;
        m           = mb;
        take_branch = tbv;
        imem_ready  = ir;
        dmem_ready  = dr;
        q.push_back(e);
        ncyc++;
    endtask

    task automatic start();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_func = 5'd0;
        q.push_back(blank(3'd0, 5'd0));
    endtask

    // Expected cycles of one instruction from IF through PCU.
    task automatic run_instr(input logic [3:0] op, input logic mb,
                             input logic tbv, input int iw, input int dw,
                             output int cyc);
        logic [4:0] f;
        kind_t      k;
        exp_t       e;
        f    = model_func(op, mb);
        k    = model_kind(f);
        ncyc = 0;
        for (int i = 0; i <= iw; i++) begin
            e = blank(3'd2, last_func);
            e.imem_read = 1'b1;
            e.ir_en     = (i == iw);
            step(~op, ~mb, ~tbv, (i == iw), 1'b1, e);
        end
        step(op, mb, ~tbv, 1'b1, 1'b1, blank(3'd3, last_func));
        last_func = f;
        step(op, mb, ~tbv, 1'b1, 1'b1, blank(3'd4, f));
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= dw; i++) begin
                e = blank(3'd5, f);
                e.mem_read  = (k == K_LOAD);
                e.mem_write = (k == K_STORE);
                step(op, mb, ~tbv, 1'b1, (i == dw), e);
            end
        end
        if (k == K_ALU || k == K_LOAD || k == K_CALL) begin
            e = blank(3'd6, f);
            e.reg_en = 1'b1;
            step(op, mb, ~tbv, 1'b1, 1'b1, e);
        end
        e = blank(3'd1, f);
        e.pc_en = 1'b1;
        case (k)
            K_BR:           e.pc_src = {1'b0, tbv};
            K_JMP, K_CALL:  e.pc_src = 2'b10;
            K_RET:          e.pc_src = 2'b11;
            default:        e.pc_src = 2'b00;
        endcase
        step(op, mb, tbv, 1'b1, 1'b1, e);
        cyc = ncyc;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            ce = q.pop_front();
            ca = {state, imem_read, ir_en, pc_en, mem_read, mem_write,
                  reg_en, fault, pc_src, func,
                  sign5, wr_byte, sign_w2b, opa_src, data_in_src,
                  ra_sel, rb_sel, rw_sel, busw_src, opb_src, r7};
            checks++;
            if (ca !== ce) begin
                errors++;
                $display("FAIL cycle at %0t: got st=%0d vec=%h, want st=%0d vec=%h",
                         $time, ca.st, ca, ce.st, ce);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        rst_n       = 1'b0;
        opcode      = 4'd0;
        m           = 1'b0;
        take_branch = 1'b0;
        imem_ready  = 1'b1;
        dmem_ready  = 1'b1;
        last_func   = 5'd0;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_func", 32'(func), 32'd0);
        check("rst_strobes", 32'({imem_read, ir_en, pc_en, mem_read,
              mem_write, reg_en, fault, pc_src}), 32'd0);
        check("rst_sel", 32'({sign5, wr_byte, sign_w2b, opa_src,
              data_in_src, ra_sel, rb_sel, rw_sel, busw_src, opb_src}), 32'd0);
        check("rst_r7", 32'(r7), 32'd7);

        check("model_func_lbs", 32'(model_func(4'b0110, 1'b1)), 32'b01101);
        check("model_func_addi", 32'(model_func(4'b0011, 1'b1)), 32'b00110);
        check("model_func_beq", 32'(model_func(4'b1010, 1'b0)), 32'b10100);
        check("model_sel_call", 32'(sel_of(5'b11010)),
              32'({5'b00010, 10'b0000101110}));
        check("model_sel_lbs", 32'(sel_of(5'b01101)),
              32'({5'b10100, 10'b0100011001}));

        start();
        run_instr(4'b0001, 1'b0, 1'b0, 0, 0, n);
        check("add_cycles", 32'(n), 32'd5);
        run_instr(4'b0110, 1'b1, 1'b0, 0, 3, n);
        check("lbs_cycles", 32'(n), 32'd9);
        run_instr(4'b1010, 1'b0, 1'b1, 0, 0, n);
        check("beq_taken_cycles", 32'(n), 32'd4);
        run_instr(4'b1010, 1'b0, 1'b0, 0, 0, n);
        run_instr(4'b1101, 1'b0, 1'b0, 0, 0, n);
        check("call_cycles", 32'(n), 32'd5);
        run_instr(4'b1110, 1'b1, 1'b0, 0, 0, n);
        check("ret_cycles", 32'(n), 32'd4);
        run_instr(4'b0000, 1'b1, 1'b0, 0, 0, n);
        run_instr(4'b0010, 1'b0, 1'b0, 2, 0, n);
        check("sub_iwait_cycles", 32'(n), 32'd7);
        run_instr(4'b0011, 1'b1, 1'b0, 0, 0, n);
        run_instr(4'b0100, 1'b0, 1'b0, 0, 0, n);
        run_instr(4'b0101, 1'b0, 1'b0, 1, 2, n);
        check("lw_wait_cycles", 32'(n), 32'd9);
        run_instr(4'b0110, 1'b0, 1'b0, 0, 0, n);
        run_instr(4'b0111, 1'b0, 1'b0, 0, 0, n);
        check("sw_cycles", 32'(n), 32'd5);
        run_instr(4'b1111, 1'b0, 1'b0, 0, 1, n);
        run_instr(4'b1011, 1'b1, 1'b1, 0, 0, n);
        run_instr(4'b1000, 1'b1, 1'b0, 0, 0, n);
        run_instr(4'b1100, 1'b0, 1'b0, 0, 0, n);
        // Longest tolerated waits: ready arrives on the last allowed cycle.
        run_instr(4'b0001, 1'b0, 1'b0, MAX_WAIT, 0, n);
        run_instr(4'b0101, 1'b0, 1'b0, 0, MAX_WAIT, n);
        check("lw_maxwait_cycles", 32'(n), 32'(6 + MAX_WAIT));

        for (int i = 0; i < MAX_WAIT + 1; i++) begin
            e = blank(3'd2, last_func);
            e.imem_read = 1'b1;
            step(4'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                 1'($urandom), e);
        end
        for (int i = 0; i < 12; i++) begin
            e = blank(3'd7, last_func);
            e.fault = 1'b1;
            step(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), e);
        end
        @(negedge clk);
        #1;
        check("fault_sticky", 32'(fault), 32'd1);
        rst_n = 1'b0;
        #1;
        check("fault_cleared", 32'(fault), 32'd0);
        check("fault_rst_state", 32'(state), 32'd0);

        start();
        ncyc = 0;
        e = blank(3'd2, 5'd0);
        e.imem_read = 1'b1;
        e.ir_en     = 1'b1;
        step(4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, e);
        step(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, blank(3'd3, 5'd0));
        last_func = 5'b01110;
        step(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, blank(3'd4, last_func));
        e = blank(3'd5, last_func);
        e.mem_write = 1'b1;
        step(4'b0111, 1'b0, 1'b0, 1'b1, 1'b0, e);
        #5;
        check("sw_mem_write_held", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("sw_mem_write_drop", 32'(mem_write), 32'd0);
        check("sw_rst_state", 32'(state), 32'd0);
        check("sw_rst_func", 32'(func), 32'd0);

        start();
        run_instr(4'b0001, 1'b0, 1'b0, 0, 0, n);
        check("restart_add_cycles", 32'(n), 32'd5);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
